// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad geometry, scan states and operator indices.
package calc_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = NUM_ROWS * NUM_COLS;

    localparam int OP_CLEAR = 0;
    localparam int OP_PLUS  = 1;
    localparam int OP_MINUS = 2;
    localparam int OP_EQUAL = 3;
    localparam int NUM_OPS  = 4;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } scan_state_e;

    function automatic int unsigned popcount(input logic [KEY_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEY_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Operator push-button conditioner: 2-FF synchroniser, stability counter
// and a one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int STABLE = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(STABLE - 1)) begin
                // Counter would reach STABLE: accept the new level.
                level <= ~level;
                pulse <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with whole-frame debounce, multi-key lockout and
// operator button arbitration feeding the calculator datapath.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int FRAME_STABLE = 4,
    parameter int BTN_STABLE   = 20000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    input  logic             btn_clear,
    input  logic             btn_plus,
    input  logic             btn_minus,
    input  logic             btn_equal,
    output logic [KEY_W-1:0] keys,
    output logic             clear,
    output logic             plus,
    output logic             minus,
    output logic             equal
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (FRAME_STABLE > 0) ? $clog2(FRAME_STABLE + 1) : 1;

    logic [3:0]         row_s1;
    logic [3:0]         row_s2;
    scan_state_e        state;
    scan_state_e        state_next;
    logic [DW-1:0]      div;
    logic               tick;
    logic               done;
    logic [KEY_W-1:0]   frame;
    logic [KEY_W-1:0]   frame_next;
    logic [KEY_W-1:0]   prev_frame;
    logic [KEY_W-1:0]   stable_vec;
    logic [KEY_W-1:0]   fresh;
    logic [SW-1:0]      stable_cnt;
    logic [SW-1:0]      cnt_next;
    int unsigned        pop;
    logic               lockout;
    logic [KEY_W-1:0]   dig_req;
    logic [KEY_W-1:0]   pending;
    logic [KEY_W-1:0]   candidate;
    logic [NUM_OPS-1:0] op_req;
    logic               op_any;

    assign tick = (div == DW'(SCAN_DIV - 1));
    assign done = tick && (state == COL3);

    always_comb begin
        col_n      = 4'b1110;
        state_next = COL0;
        unique case (state)
            COL0: begin col_n = 4'b1110; state_next = COL1; end
            COL1: begin col_n = 4'b1101; state_next = COL2; end
            COL2: begin col_n = 4'b1011; state_next = COL3; end
            COL3: begin col_n = 4'b0111; state_next = COL0; end
            default: begin col_n = 4'b1110; state_next = COL0; end
        endcase
    end

    // Bit index row*4+col is simply {row, col} for a 4-column pad.
    always_comb begin
        frame_next = frame;
        for (int r = 0; r < NUM_ROWS; r++) begin
            frame_next[{2'(r), state}] = ~row_s2[r];
        end
    end

    always_comb begin
        if (frame_next != prev_frame) begin
            cnt_next = SW'(1);
        end else if (stable_cnt == SW'(FRAME_STABLE)) begin
            cnt_next = stable_cnt;
        end else begin
            cnt_next = stable_cnt + SW'(1);
        end
        pop   = popcount(frame_next);
        fresh = frame_next & ~stable_vec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            state      <= COL0;
            div        <= '0;
            frame      <= '0;
            prev_frame <= '0;
            stable_vec <= '0;
            stable_cnt <= '0;
            lockout    <= 1'b0;
            dig_req    <= '0;
        end else begin
            row_s1  <= row_n;
            row_s2  <= row_s1;
            dig_req <= '0;
            if (tick) begin
                div   <= '0;
                state <= state_next;
                frame <= frame_next;
            end else begin
                div <= div + DW'(1);
            end
            if (done) begin
                prev_frame <= frame_next;
                stable_cnt <= cnt_next;
                if (cnt_next == SW'(FRAME_STABLE)) begin
                    stable_vec <= frame_next;
                    if (frame_next == '0) begin
                        lockout <= 1'b0;
                    end else if (pop > 1) begin
                        lockout <= 1'b1;
                    end
                    if (pop == 1 && fresh != '0 && !lockout) begin
                        dig_req <= fresh;
                    end
                end
            end
        end
    end

    btn_debounce #(.STABLE(BTN_STABLE)) u_clear (
        .clock (clock),
        .reset (reset),
        .raw   (btn_clear),
        .pulse (op_req[OP_CLEAR])
    );

    btn_debounce #(.STABLE(BTN_STABLE)) u_plus (
        .clock (clock),
        .reset (reset),
        .raw   (btn_plus),
        .pulse (op_req[OP_PLUS])
    );

    btn_debounce #(.STABLE(BTN_STABLE)) u_minus (
        .clock (clock),
        .reset (reset),
        .raw   (btn_minus),
        .pulse (op_req[OP_MINUS])
    );

    btn_debounce #(.STABLE(BTN_STABLE)) u_equal (
        .clock (clock),
        .reset (reset),
        .raw   (btn_equal),
        .pulse (op_req[OP_EQUAL])
    );

    assign op_any    = |op_req;
    assign candidate = (dig_req != '0) ? dig_req : pending;

    // Operators win the cycle; a colliding digit waits one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            keys    <= '0;
            pending <= '0;
            clear   <= 1'b0;
            plus    <= 1'b0;
            minus   <= 1'b0;
            equal   <= 1'b0;
        end else begin
            clear <= op_req[OP_CLEAR];
            plus  <= op_req[OP_PLUS] & ~op_req[OP_CLEAR];
            minus <= op_req[OP_MINUS] & ~|op_req[OP_PLUS:OP_CLEAR];
            equal <= op_req[OP_EQUAL] & ~|op_req[OP_MINUS:OP_CLEAR];
            if (op_any) begin
                keys    <= '0;
                pending <= candidate;
            end else begin
                keys    <= candidate;
                pending <= '0;
            end
        end
    end

endmodule
